alarm_trigger: RTL and testbench

Consumer side of the alarm-time interface. Compares the alarm time set by the user against the running time-of-day and starts ringing on a match. While ringing it drives the buzzer, accepts stop and snooze buttons, and times out unanswered alarms. It sits between the alarm-settings block and the time counter on one side, and the buzzer/LED pins on the other.

---
 rtl/alarm_pkg.sv | 28 ++
 rtl/alarm_trigger_if.sv | 27 ++
 rtl/alarm_trigger_button_edge.sv | 32 +++
 rtl/alarm_trigger.sv | 173 +++++++++++++++++
 tb/tb_alarm_trigger.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm trigger block.
package alarm_pkg;

  // Alarm controller states; ringing/snoozed outputs decode directly from these.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZED = 2'd2
  } alarm_state_t;

  // Legal ranges of the binary time-of-day fields.
  localparam logic [7:0] HOURS_MAX = 8'd23;
  localparam logic [7:0] MINS_MAX  = 8'd59;
  localparam logic [7:0] SECS_MAX  = 8'd59;

  // True when the alarm time and the current time agree on all three fields.
  function automatic logic time_eq(
    input logic [7:0] a_hour,
    input logic [7:0] a_minute,
    input logic [7:0] a_second,
    input logic [7:0] c_hour,
    input logic [7:0] c_minute,
    input logic [7:0] c_second
  );
    return (a_hour == c_hour) && (a_minute == c_minute) && (a_second == c_second);
  endfunction

endpackage

// File: rtl/alarm_trigger_if.sv
// Alarm-time interface: alarm settings and running time-of-day fed to the trigger.
interface alarm_trigger_if;
  import alarm_pkg::*;

  logic       mode;
  logic       alarm_enable;
  logic [7:0] alarm_hour;
  logic [7:0] alarm_minute;
  logic [7:0] alarm_second;
  logic [7:0] cur_hour;
  logic [7:0] cur_minute;
  logic [7:0] cur_second;

  // Settings block and time counter drive the fields.
  modport master (
    output mode, alarm_enable,
    output alarm_hour, alarm_minute, alarm_second,
    output cur_hour, cur_minute, cur_second
  );

  // The alarm trigger only observes them.
  modport slave (
    input mode, alarm_enable,
    input alarm_hour, alarm_minute, alarm_second,
    input cur_hour, cur_minute, cur_second
  );
endinterface

// File: rtl/alarm_trigger_button_edge.sv
// Push-button conditioning: two-flop synchroniser followed by a falling-edge
// detector. A press is seen as a one-cycle pulse that is sampled on the third
// rising clock edge after the pin goes low; a held button gives one pulse.
module button_edge
  import alarm_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic press
);

  logic sync1_r;
  logic sync2_r;
  logic prev_r;

  // Synchronise the asynchronous pin and keep one delayed copy for edge detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      prev_r  <= 1'b1;
    end else begin
      sync1_r <= btn_n;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  assign press = prev_r & ~sync2_r;

endmodule

// File: rtl/alarm_trigger.sv
// Alarm trigger: detects the alarm time, rings the buzzer, handles stop and
// snooze buttons, and auto-stops unanswered alarms (flagging them as missed).
module alarm_trigger
  import alarm_pkg::*;
#(
  parameter int TONE_DIV       = 25000,
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_SECONDS = 300,
  parameter int MAX_SNOOZE     = 3
) (
  input  logic            clk,
  input  logic            rst,
  alarm_trigger_if.slave  tif,
  input  logic            stop_n,
  input  logic            snooze_n,
  output logic            ringing,
  output logic            snoozed,
  output logic            buzzer,
  output logic            missed
);

  localparam int                USED_W    = $clog2(MAX_SNOOZE + 1);
  localparam logic [15:0]       RING_LAST = 16'(RING_SECONDS - 1);
  localparam logic [15:0]       SNZ_LAST  = 16'(SNOOZE_SECONDS - 1);
  localparam logic [31:0]       TONE_LAST = 32'(TONE_DIV - 1);
  localparam logic [USED_W-1:0] SNZ_LIMIT = USED_W'(MAX_SNOOZE);
  localparam logic [USED_W-1:0] USED_ONE  = USED_W'(1);

  alarm_state_t      state_r;
  logic              match_s;
  logic              match_q_r;
  logic              trigger_s;
  logic [7:0]        sec_q_r;
  logic              sec_valid_r;
  logic              sec_tick_s;
  logic              stop_press_s;
  logic              snooze_press_s;
  logic [15:0]       ring_cnt_r;
  logic [15:0]       snz_cnt_r;
  logic [31:0]       tone_cnt_r;
  logic              tone_r;
  logic [USED_W-1:0] used_r;
  logic              missed_r;

  button_edge u_stop_btn (
    .clk   (clk),
    .rst   (rst),
    .btn_n (stop_n),
    .press (stop_press_s)
  );

  button_edge u_snooze_btn (
    .clk   (clk),
    .rst   (rst),
    .btn_n (snooze_n),
    .press (snooze_press_s)
  );

  // Match, rising-edge trigger and one-second tick decode.
  always_comb begin
    match_s = 1'b0;
    if (tif.alarm_enable && !tif.mode) begin
      match_s = time_eq(tif.alarm_hour, tif.alarm_minute, tif.alarm_second,
                        tif.cur_hour, tif.cur_minute, tif.cur_second);
    end else begin
      match_s = 1'b0;
    end
    trigger_s  = match_s & ~match_q_r;
    sec_tick_s = sec_valid_r & (tif.cur_second != sec_q_r);
  end

  // History of match and seconds; match_q starts high so a match present at
  // reset release is not treated as a new alarm, and the first cycle never ticks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_q_r   <= 1'b1;
      sec_q_r     <= 8'd0;
      sec_valid_r <= 1'b0;
    end else begin
      match_q_r   <= match_s;
      sec_q_r     <= tif.cur_second;
      sec_valid_r <= 1'b1;
    end
  end

  // Alarm FSM with ring/snooze/tone counters; priority is
  // disable > stop > snooze > timeout/expiry > tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      ring_cnt_r <= 16'd0;
      snz_cnt_r  <= 16'd0;
      tone_cnt_r <= 32'd0;
      tone_r     <= 1'b0;
      used_r     <= {USED_W{1'b0}};
      missed_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (trigger_s) begin
            state_r    <= RINGING;
            ring_cnt_r <= 16'd0;
            used_r     <= {USED_W{1'b0}};
            missed_r   <= 1'b0;
          end else if (stop_press_s) begin
            missed_r   <= 1'b0;
          end
        end

        RINGING: begin
          // Tone generator runs while ringing; leaving clears it below.
          if (tone_cnt_r == TONE_LAST) begin
            tone_cnt_r <= 32'd0;
            tone_r     <= ~tone_r;
          end else begin
            tone_cnt_r <= tone_cnt_r + 32'd1;
          end

          if (!tif.alarm_enable || stop_press_s) begin
            state_r    <= IDLE;
            tone_cnt_r <= 32'd0;
            tone_r     <= 1'b0;
          end else if (snooze_press_s) begin
            if (used_r < SNZ_LIMIT) begin
              state_r   <= SNOOZED;
              snz_cnt_r <= 16'd0;
              used_r    <= used_r + USED_ONE;
            end else begin
              state_r   <= IDLE;
            end
            tone_cnt_r <= 32'd0;
            tone_r     <= 1'b0;
          end else if (sec_tick_s) begin
            if (ring_cnt_r == RING_LAST) begin
              state_r    <= IDLE;
              missed_r   <= 1'b1;
              tone_cnt_r <= 32'd0;
              tone_r     <= 1'b0;
            end else begin
              ring_cnt_r <= ring_cnt_r + 16'd1;
            end
          end
        end

        SNOOZED: begin
          if (!tif.alarm_enable || stop_press_s) begin
            state_r <= IDLE;
          end else if (sec_tick_s) begin
            if (snz_cnt_r == SNZ_LAST) begin
              state_r    <= RINGING;
              ring_cnt_r <= 16'd0;
            end else begin
              snz_cnt_r  <= snz_cnt_r + 16'd1;
            end
          end
        end

        default: begin
          state_r    <= IDLE;
          tone_cnt_r <= 32'd0;
          tone_r     <= 1'b0;
        end
      endcase
    end
  end

  assign ringing = (state_r == RINGING);
  assign snoozed = (state_r == SNOOZED);
  assign missed  = missed_r;
  // Beep on even seconds only: 1 s tone, 1 s silence.
  assign buzzer  = tone_r & ~tif.cur_second[0];

endmodule

// File: tb/tb_alarm_trigger.sv
// Self-checking bench for alarm_trigger: directed scenarios plus randomized
// traffic, all checked every cycle against a behavioural reference model.
module tb_alarm_trigger;

  localparam int TONE_DIV = 4;
  localparam int RING_S   = 5;
  localparam int SNZ_S    = 3;
  localparam int MAX_SNZ  = 2;

  localparam int M_IDLE = 0;
  localparam int M_RING = 1;
  localparam int M_SNZ  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stop_n = 1'b1;
  logic snooze_n = 1'b1;
  logic ringing, snoozed, buzzer, missed;

  alarm_trigger_if tif ();

  alarm_trigger #(
    .TONE_DIV       (TONE_DIV),
    .RING_SECONDS   (RING_S),
    .SNOOZE_SECONDS (SNZ_S),
    .MAX_SNOOZE     (MAX_SNZ)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tif      (tif),
    .stop_n   (stop_n),
    .snooze_n (snooze_n),
    .ringing  (ringing),
    .snoozed  (snoozed),
    .buzzer   (buzzer),
    .missed   (missed)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_bad    = 0;

  // Reference model: seconds-remaining countdowns and pin history.
  int         m_st;
  int         m_ring_left;
  int         m_snz_left;
  int         m_snz_avail;
  int         m_k;
  bit         m_missed;
  bit         m_mq;
  bit         m_seen;
  logic [7:0] m_prev_sec;
  bit [2:0]   stop_h;
  bit [2:0]   snz_h;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = M_IDLE; m_ring_left = 0; m_snz_left = 0; m_snz_avail = 0; m_k = 0;
    m_missed = 1'b0; m_mq = 1'b1; m_seen = 1'b0; m_prev_sec = 8'd0;
    stop_h = 3'b111; snz_h = 3'b111;
  endtask

  // Advance the model by one clock edge using the inputs presented to the DUT.
  task automatic model_edge();
    bit match, trig, tick, sp, zp;
    match = tif.alarm_enable && !tif.mode && (tif.alarm_hour == tif.cur_hour) &&
            (tif.alarm_minute == tif.cur_minute) && (tif.alarm_second == tif.cur_second);
    trig = match && !m_mq;
    tick = m_seen && (tif.cur_second != m_prev_sec);
    sp   = stop_h[2] && !stop_h[1];
    zp   = snz_h[2] && !snz_h[1];
    case (m_st)
      M_IDLE: begin
        if (trig) begin
          m_st = M_RING; m_ring_left = RING_S; m_snz_avail = MAX_SNZ; m_missed = 1'b0; m_k = 0;
        end else if (sp) m_missed = 1'b0;
      end
      M_RING: begin
        if (!tif.alarm_enable || sp) m_st = M_IDLE;
        else if (zp) begin
          if (m_snz_avail > 0) begin
            m_snz_avail--; m_st = M_SNZ; m_snz_left = SNZ_S;
          end else m_st = M_IDLE;
        end else if (tick) begin
          m_ring_left--;
          if (m_ring_left == 0) begin m_st = M_IDLE; m_missed = 1'b1; end
        end
        if (m_st == M_RING) m_k++; else m_k = 0;
      end
      M_SNZ: begin
        if (!tif.alarm_enable || sp) m_st = M_IDLE;
        else if (tick) begin
          m_snz_left--;
          if (m_snz_left == 0) begin m_st = M_RING; m_ring_left = RING_S; m_k = 0; end
        end
      end
      default: m_st = M_IDLE;
    endcase
    m_mq = match; m_seen = 1'b1; m_prev_sec = tif.cur_second;
    stop_h = {stop_h[1:0], stop_n};
    snz_h  = {snz_h[1:0], snooze_n};
  endtask

  task automatic compare_all();
    check_val("ringing", ringing, (m_st == M_RING));
    check_val("snoozed", snoozed, (m_st == M_SNZ));
    check_val("buzzer", buzzer, (m_st == M_RING) && (((m_k / TONE_DIV) % 2) == 1) &&
                                (tif.cur_second[0] == 1'b0));
    check_val("missed", missed, m_missed);
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      model_edge();
      @(posedge clk);
      #1;
      compare_all();
    end
  endtask

  task automatic set_cur(input int h, input int m, input int s);
    tif.cur_hour = 8'(h); tif.cur_minute = 8'(m); tif.cur_second = 8'(s);
  endtask

  task automatic set_alarm(input int h, input int m, input int s);
    tif.alarm_hour = 8'(h); tif.alarm_minute = 8'(m); tif.alarm_second = 8'(s);
  endtask

  // Asynchronous reset pulse mid-cycle; outputs must clear without a clock edge.
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    check_val({tag, "_ring"}, ringing, 1'b0);
    check_val({tag, "_snz"}, snoozed, 1'b0);
    check_val({tag, "_buz"}, buzzer, 1'b0);
    check_val({tag, "_miss"}, missed, 1'b0);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sec;
    int stop_cnt;
    int snz_cnt;
    model_reset();
    tif.mode = 1'b0; tif.alarm_enable = 1'b1;
    set_alarm(0, 0, 0); set_cur(0, 0, 0);
    @(posedge clk);
    #1;
    compare_all();
    rst = 1'b0;

    // 1: alarm 00:00:00 at reset release does not fire; a fresh match does.
    cyc(3);
    check_val("t1_quiet", ringing, 1'b0);
    set_cur(0, 0, 1); cyc(2);
    set_alarm(0, 0, 1); cyc(1);
    check_val("t1_ring", ringing, 1'b1);
    stop_n = 1'b0; cyc(2);
    check_val("t1_stop_wait", ringing, 1'b1);
    cyc(1);
    check_val("t1_stop", ringing, 1'b0);
    cyc(3); stop_n = 1'b1; cyc(3);
    check_val("t1_noretrig", ringing, 1'b0);

    // 2: unanswered alarm times out and sets missed; stop in IDLE clears it.
    set_alarm(7, 30, 0); set_cur(7, 29, 59); cyc(3);
    set_cur(7, 30, 0); cyc(1);
    check_val("t2_ring", ringing, 1'b1);
    for (int s = 1; s <= 6; s++) begin
      set_cur(7, 30, s); cyc(3);
      if (s == 4) check_val("t2_ring4", ringing, 1'b1);
    end
    check_val("t2_timeout", ringing, 1'b0);
    check_val("t2_missed", missed, 1'b1);
    check_val("t2_buz", buzzer, 1'b0);
    stop_n = 1'b0; cyc(3);
    check_val("t2_clear", missed, 1'b0);
    stop_n = 1'b1; cyc(2);

    // 3: held snooze acts once on the 3rd edge; re-rings after SNZ_S ticks.
    set_alarm(8, 0, 0); set_cur(7, 59, 59); cyc(2);
    set_cur(8, 0, 0); cyc(1);
    snooze_n = 1'b0; cyc(2);
    check_val("t3_snz_wait", snoozed, 1'b0);
    cyc(1);
    check_val("t3_snz", snoozed, 1'b1);
    cyc(7); snooze_n = 1'b1;
    check_val("t3_snz_hold", snoozed, 1'b1);
    for (int s = 1; s <= 3; s++) begin set_cur(8, 0, s); cyc(2); end
    check_val("t3_rering", ringing, 1'b1);

    // 4: second snooze allowed, third acts as stop; stop beats snooze.
    snooze_n = 1'b0; cyc(4); snooze_n = 1'b1; cyc(2);
    check_val("t4_snz2", snoozed, 1'b1);
    for (int s = 4; s <= 6; s++) begin set_cur(8, 0, s); cyc(2); end
    check_val("t4_rering2", ringing, 1'b1);
    snooze_n = 1'b0; cyc(4); snooze_n = 1'b1; cyc(1);
    check_val("t4_third_ring", ringing, 1'b0);
    check_val("t4_third_snz", snoozed, 1'b0);
    set_alarm(9, 0, 0); set_cur(8, 59, 59); cyc(2);
    set_cur(9, 0, 0); cyc(1);
    stop_n = 1'b0; snooze_n = 1'b0; cyc(3);
    check_val("t4_stopwins_ring", ringing, 1'b0);
    check_val("t4_stopwins_snz", snoozed, 1'b0);
    stop_n = 1'b1; snooze_n = 1'b1; cyc(2);

    // 5: mode suppresses the match; leaving mode in the same second triggers.
    set_alarm(10, 0, 0); set_cur(9, 59, 59); cyc(2);
    tif.mode = 1'b1; set_cur(10, 0, 0); cyc(3);
    check_val("t5_mode", ringing, 1'b0);
    tif.mode = 1'b0; cyc(1);
    check_val("t5_rise", ringing, 1'b1);

    // 6: buzzer toggles on the even second; async reset mid-ring.
    cyc(12);
    check_val("t6_pre", ringing, 1'b1);
    async_reset("t6_rst");
    cyc(4);

    // Randomized traffic.
    set_alarm(12, 0, 3); set_cur(12, 0, 0);
    sec = 0; stop_cnt = 0; snz_cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        sec = (sec + 1) % 8;
        tif.cur_second = 8'(sec);
      end
      if ($urandom_range(0, 39) == 0) tif.alarm_second = 8'($urandom_range(0, 7));
      tif.alarm_enable = ($urandom_range(0, 199) != 0);
      tif.mode = ($urandom_range(0, 149) == 0);
      if (stop_cnt > 0) stop_cnt--;
      else if ($urandom_range(0, 79) == 0) stop_cnt = $urandom_range(1, 8);
      stop_n = (stop_cnt == 0);
      if (snz_cnt > 0) snz_cnt--;
      else if ($urandom_range(0, 24) == 0) snz_cnt = $urandom_range(1, 8);
      snooze_n = (snz_cnt == 0);
      if ($urandom_range(0, 999) == 0) begin
        async_reset("rnd_rst");
        stop_cnt = 0; snz_cnt = 0; stop_n = 1'b1; snooze_n = 1'b1;
      end
      cyc(1);
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
